// File: rtl/store_checker_pkg.sv
// Shared types and constants for the store checker: FSM states, verdict codes, match modes.
package store_checker_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PASS = 2'd2,
    FAIL = 2'd3
  } chk_state_t;

  typedef enum logic [1:0] {
    FC_NONE     = 2'd0,
    FC_MISMATCH = 2'd1,
    FC_TIMEOUT  = 2'd2
  } fail_code_t;

  localparam logic MODE_STRICT = 1'b0;
  localparam logic MODE_LOOSE  = 1'b1;

  // Table index width; a single-entry table still gets one index bit.
  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/store_checker_if.sv
// Bundle of the observed store port, table programming, run configuration and verdict outputs.
interface store_checker_if
  import store_checker_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 8,
  parameter int TOW   = 16
);
  localparam int IDXW = idx_width(DEPTH);

  // MemWrite is a valid-only strobe: the checker is always ready, so every
  // cycle MemWrite is sampled high counts as exactly one store of DataAdr/WriteData.
  logic            MemWrite;
  logic [XLEN-1:0] DataAdr;
  logic [XLEN-1:0] WriteData;

  logic            cfg_we;
  logic [IDXW-1:0] cfg_idx;
  logic [XLEN-1:0] cfg_adr;
  logic [XLEN-1:0] cfg_data;

  logic            start;
  logic [IDXW:0]   num_exp;
  logic            mode;
  logic [TOW-1:0]  timeout;
  logic            ign_en;
  logic [XLEN-1:0] ign_lo;
  logic [XLEN-1:0] ign_hi;

  logic            done;
  logic            pass;
  fail_code_t      fail_code;
  logic [IDXW-1:0] fail_idx;
  logic [XLEN-1:0] fail_adr;
  logic [XLEN-1:0] fail_data;
  logic [IDXW:0]   match_cnt;
  logic [TOW-1:0]  ign_cnt;

  modport master (
    output MemWrite, DataAdr, WriteData,
    output cfg_we, cfg_idx, cfg_adr, cfg_data,
    output start, num_exp, mode, timeout, ign_en, ign_lo, ign_hi,
    input  done, pass, fail_code, fail_idx, fail_adr, fail_data, match_cnt, ign_cnt
  );

  modport slave (
    input  MemWrite, DataAdr, WriteData,
    input  cfg_we, cfg_idx, cfg_adr, cfg_data,
    input  start, num_exp, mode, timeout, ign_en, ign_lo, ign_hi,
    output done, pass, fail_code, fail_idx, fail_adr, fail_data, match_cnt, ign_cnt
  );

endinterface

// File: rtl/store_checker_table.sv
// Expected-store table: one synchronous write port, one asynchronous read port.
module store_checker_table #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 8,
  parameter int IDXW  = 3
) (
  input  logic            clk_i,
  input  logic            we_i,
  input  logic [IDXW-1:0] widx_i,
  input  logic [XLEN-1:0] wadr_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic [IDXW-1:0] ridx_i,
  output logic [XLEN-1:0] radr_o,
  output logic [XLEN-1:0] rdata_o
);

  // Contents are intentionally not reset; they survive a checker reset.
  logic [2*XLEN-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i && (int'(widx_i) < DEPTH)) begin
      mem_q[widx_i] <= {wadr_i, wdata_i};
    end
  end

  assign {radr_o, rdata_o} = (int'(ridx_i) < DEPTH) ? mem_q[ridx_i] : '0;

endmodule

// File: rtl/store_checker.sv
// Store checker: matches core stores against a programmed table and reports a held pass/fail verdict.
module store_checker
  import store_checker_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 8,
  parameter int TOW   = 16
) (
  input  logic           clk,
  input  logic           reset,
  store_checker_if.slave bus,
  output chk_state_t     dbg_state_o
);

  localparam int IDXW = idx_width(DEPTH);
  localparam logic [IDXW:0] DEPTH_L = (IDXW+1)'(DEPTH);

  chk_state_t      state_q, state_d;
  logic [IDXW:0]   num_exp_q, num_exp_d;
  logic            mode_q, mode_d;
  logic [TOW-1:0]  timeout_q, timeout_d;
  logic            ign_en_q, ign_en_d;
  logic [XLEN-1:0] ign_lo_q, ign_lo_d;
  logic [XLEN-1:0] ign_hi_q, ign_hi_d;
  logic [TOW-1:0]  cyc_q, cyc_d;
  logic [IDXW:0]   match_cnt_q, match_cnt_d;
  logic [TOW-1:0]  ign_cnt_q, ign_cnt_d;
  fail_code_t      fail_code_q, fail_code_d;
  logic [IDXW-1:0] fail_idx_q, fail_idx_d;
  logic [XLEN-1:0] fail_adr_q, fail_adr_d;
  logic [XLEN-1:0] fail_data_q, fail_data_d;

  logic [XLEN-1:0] tbl_adr, tbl_data;
  logic            store, in_win, hit;

  store_checker_table #(.XLEN(XLEN), .DEPTH(DEPTH), .IDXW(IDXW)) u_table (
    .clk_i   (clk),
    .we_i    (bus.cfg_we && (state_q == IDLE)),
    .widx_i  (bus.cfg_idx),
    .wadr_i  (bus.cfg_adr),
    .wdata_i (bus.cfg_data),
    .ridx_i  (match_cnt_q[IDXW-1:0]),
    .radr_o  (tbl_adr),
    .rdata_o (tbl_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      num_exp_q   <= '0;
      mode_q      <= MODE_STRICT;
      timeout_q   <= '0;
      ign_en_q    <= 1'b0;
      ign_lo_q    <= '0;
      ign_hi_q    <= '0;
      cyc_q       <= '0;
      match_cnt_q <= '0;
      ign_cnt_q   <= '0;
      fail_code_q <= FC_NONE;
      fail_idx_q  <= '0;
      fail_adr_q  <= '0;
      fail_data_q <= '0;
    end else begin
      state_q     <= state_d;
      num_exp_q   <= num_exp_d;
      mode_q      <= mode_d;
      timeout_q   <= timeout_d;
      ign_en_q    <= ign_en_d;
      ign_lo_q    <= ign_lo_d;
      ign_hi_q    <= ign_hi_d;
      cyc_q       <= cyc_d;
      match_cnt_q <= match_cnt_d;
      ign_cnt_q   <= ign_cnt_d;
      fail_code_q <= fail_code_d;
      fail_idx_q  <= fail_idx_d;
      fail_adr_q  <= fail_adr_d;
      fail_data_q <= fail_data_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    num_exp_d   = num_exp_q;
    mode_d      = mode_q;
    timeout_d   = timeout_q;
    ign_en_d    = ign_en_q;
    ign_lo_d    = ign_lo_q;
    ign_hi_d    = ign_hi_q;
    cyc_d       = cyc_q;
    match_cnt_d = match_cnt_q;
    ign_cnt_d   = ign_cnt_q;
    fail_code_d = fail_code_q;
    fail_idx_d  = fail_idx_q;
    fail_adr_d  = fail_adr_q;
    fail_data_d = fail_data_q;

    // An unknown strobe takes the else path in simulation and is not a store.
    store = 1'b0;
    if (bus.MemWrite) store = 1'b1;
    in_win = ign_en_q && (bus.DataAdr >= ign_lo_q) && (bus.DataAdr <= ign_hi_q);
    hit    = (bus.DataAdr == tbl_adr) && (bus.WriteData == tbl_data);

    case (state_q)
      RUN: begin
        if (cyc_q != '1) cyc_d = cyc_q + 1'b1;
        if (num_exp_q == '0) begin
          state_d = PASS;
        end else begin
          if (store) begin
            if (in_win) begin
              if (ign_cnt_q != '1) ign_cnt_d = ign_cnt_q + 1'b1;
            end else if (hit) begin
              match_cnt_d = match_cnt_q + 1'b1;
              if (match_cnt_d == num_exp_q) state_d = PASS;
            end else if (mode_q == MODE_STRICT) begin
              state_d     = FAIL;
              fail_code_d = FC_MISMATCH;
              fail_idx_d  = match_cnt_q[IDXW-1:0];
              fail_adr_d  = bus.DataAdr;
              fail_data_d = bus.WriteData;
            end
          end
          // A completing match in the watchdog's last cycle keeps its PASS.
          if ((state_d == RUN) && (timeout_q != '0) && (cyc_q == timeout_q - 1'b1)) begin
            state_d     = FAIL;
            fail_code_d = FC_TIMEOUT;
            fail_idx_d  = match_cnt_d[IDXW-1:0];
            fail_adr_d  = '0;
            fail_data_d = '0;
          end
        end
      end
      default: begin
        if (bus.start) begin
          state_d     = RUN;
          num_exp_d   = (bus.num_exp > DEPTH_L) ? DEPTH_L : bus.num_exp;
          mode_d      = bus.mode ? MODE_LOOSE : MODE_STRICT;
          timeout_d   = bus.timeout;
          ign_en_d    = bus.ign_en;
          ign_lo_d    = bus.ign_lo;
          ign_hi_d    = bus.ign_hi;
          cyc_d       = '0;
          match_cnt_d = '0;
          ign_cnt_d   = '0;
          fail_code_d = FC_NONE;
          fail_idx_d  = '0;
          fail_adr_d  = '0;
          fail_data_d = '0;
        end
      end
    endcase
  end

  assign bus.done      = (state_q == PASS) || (state_q == FAIL);
  assign bus.pass      = (state_q == PASS);
  assign bus.fail_code = fail_code_q;
  assign bus.fail_idx  = fail_idx_q;
  assign bus.fail_adr  = fail_adr_q;
  assign bus.fail_data = fail_data_q;
  assign bus.match_cnt = match_cnt_q;
  assign bus.ign_cnt   = ign_cnt_q;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_store_checker.sv
// Bench for store_checker: a vector table for ordered/skipping matching plus hand sequences for timing corners.
module tb_store_checker;
  import store_checker_pkg::*;

  typedef struct packed {
    logic        done;
    logic        pass;
    logic [1:0]  fc;
    logic [2:0]  fidx;
    logic [31:0] fadr;
    logic [31:0] fdata;
    logic [3:0]  mcnt;
    logic [15:0] icnt;
  } res_t;

  localparam int RW = $bits(res_t);

  typedef struct {
    string       name;
    logic        start;
    logic        we;
    logic [31:0] adr;
    logic [31:0] data;
    res_t        exp;
  } vec_t;

  logic       clk;
  logic       reset;
  chk_state_t dbg_state;
  int         n_vec;
  int         n_bad;
  vec_t       vecs[15];
  logic [RW-1:0] exp_q[$];

  store_checker_if #(.XLEN(32), .DEPTH(8), .TOW(16)) bus ();

  store_checker #(.XLEN(32), .DEPTH(8), .TOW(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic prog(input int idx, input int a, input int d);
    bus.cfg_we   = 1'b1;
    bus.cfg_idx  = 3'(idx);
    bus.cfg_adr  = 32'(a);
    bus.cfg_data = 32'(d);
    tick();
    bus.cfg_we = 1'b0;
  endtask

  task automatic set_cfg(input int num, input int md, input int to, input int ie,
                         input int lo, input int hi);
    bus.num_exp = 4'(num);
    bus.mode    = md[0];
    bus.timeout = 16'(to);
    bus.ign_en  = ie[0];
    bus.ign_lo  = 32'(lo);
    bus.ign_hi  = 32'(hi);
  endtask

  task automatic drive(input int st, input int we, input int a, input int d);
    bus.start     = st[0];
    bus.MemWrite  = we[0];
    bus.DataAdr   = 32'(a);
    bus.WriteData = 32'(d);
    tick();
    bus.start    = 1'b0;
    bus.MemWrite = 1'b0;
  endtask

  // ---------------- scoreboard ----------------
  function automatic res_t mk_res(input int d, input int p, input int fc, input int fi,
                                  input int fa, input int fd, input int mc, input int ic);
    res_t r;
    r.done  = d[0];
    r.pass  = p[0];
    r.fc    = 2'(fc);
    r.fidx  = 3'(fi);
    r.fadr  = 32'(fa);
    r.fdata = 32'(fd);
    r.mcnt  = 4'(mc);
    r.icnt  = 16'(ic);
    return r;
  endfunction

  function automatic vec_t mk_vec(input string nm, input int st, input int we,
                                  input int a, input int d, input res_t e);
    vec_t v;
    v.name  = nm;
    v.start = st[0];
    v.we    = we[0];
    v.adr   = 32'(a);
    v.data  = 32'(d);
    v.exp   = e;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  task automatic check_res(input string nm, input res_t e);
    check({nm, ".done"},      32'(bus.done),      32'(e.done));
    check({nm, ".pass"},      32'(bus.pass),      32'(e.pass));
    check({nm, ".fail_code"}, 32'(bus.fail_code), 32'(e.fc));
    check({nm, ".fail_idx"},  32'(bus.fail_idx),  32'(e.fidx));
    check({nm, ".fail_adr"},  bus.fail_adr,       e.fadr);
    check({nm, ".fail_data"}, bus.fail_data,      e.fdata);
    check({nm, ".match_cnt"}, 32'(bus.match_cnt), 32'(e.mcnt));
    check({nm, ".ign_cnt"},   32'(bus.ign_cnt),   32'(e.icnt));
  endtask

  task automatic check_state(input string nm, input chk_state_t exp);
    check({nm, ".state"}, 32'(dbg_state), 32'(exp));
  endtask

  task automatic run_vectors(input int first, input int last);
    for (int i = first; i <= last; i++) begin
      bus.start     = vecs[i].start;
      bus.MemWrite  = vecs[i].we;
      bus.DataAdr   = vecs[i].adr;
      bus.WriteData = vecs[i].data;
      exp_q.push_back(vecs[i].exp);
      tick();
      bus.start    = 1'b0;
      bus.MemWrite = 1'b0;
      check_res(vecs[i].name, res_t'(exp_q.pop_front()));
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    n_vec = 0;
    n_bad = 0;
    reset = 1'b1;
    bus.MemWrite = 1'b0; bus.DataAdr = '0; bus.WriteData = '0;
    bus.cfg_we = 1'b0; bus.cfg_idx = '0; bus.cfg_adr = '0; bus.cfg_data = '0;
    bus.start = 1'b0;
    set_cfg(0, 0, 0, 0, 0, 0);

    // Ordered hit with an ignored store, then a rerun that mismatches.
    vecs[0]  = mk_vec("t1_start",  1, 0, 0,   0,  mk_res(0, 0, 0, 0, 0,   0,  0, 0));
    vecs[1]  = mk_vec("t1_ign96",  0, 1, 96,  7,  mk_res(0, 0, 0, 0, 0,   0,  0, 1));
    vecs[2]  = mk_vec("t1_hit100", 0, 1, 100, 25, mk_res(1, 1, 0, 0, 0,   0,  1, 1));
    vecs[3]  = mk_vec("t1_hold",   0, 0, 0,   0,  mk_res(1, 1, 0, 0, 0,   0,  1, 1));
    vecs[4]  = mk_vec("t2_start",  1, 0, 0,   0,  mk_res(0, 0, 0, 0, 0,   0,  0, 0));
    vecs[5]  = mk_vec("t2_ign96",  0, 1, 96,  7,  mk_res(0, 0, 0, 0, 0,   0,  0, 1));
    vecs[6]  = mk_vec("t2_miss",   0, 1, 104, 25, mk_res(1, 0, 1, 0, 104, 25, 0, 1));
    vecs[7]  = mk_vec("t2_hold",   0, 0, 0,   0,  mk_res(1, 0, 1, 0, 104, 25, 0, 1));
    // Skipping mode: out-of-order and corrupted stores are dropped.
    vecs[8]  = mk_vec("t3_start",  1, 0, 0,   0,  mk_res(0, 0, 0, 0, 0,   0,  0, 0));
    vecs[9]  = mk_vec("t3_skip42", 0, 1, 4,   2,  mk_res(0, 0, 0, 0, 0,   0,  0, 0));
    vecs[10] = mk_vec("t3_hit01",  0, 1, 0,   1,  mk_res(0, 0, 0, 0, 0,   0,  1, 0));
    vecs[11] = mk_vec("t3_skip89", 0, 1, 8,   9,  mk_res(0, 0, 0, 0, 0,   0,  1, 0));
    vecs[12] = mk_vec("t3_hit42",  0, 1, 4,   2,  mk_res(0, 0, 0, 0, 0,   0,  2, 0));
    vecs[13] = mk_vec("t3_hit83",  0, 1, 8,   3,  mk_res(1, 1, 0, 0, 0,   0,  3, 0));
    vecs[14] = mk_vec("t3_hold",   0, 0, 0,   0,  mk_res(1, 1, 0, 0, 0,   0,  3, 0));

    do_reset();
    check_res("reset", mk_res(0, 0, 0, 0, 0, 0, 0, 0));
    check_state("reset", IDLE);

    prog(0, 100, 25);
    set_cfg(1, 0, 0, 1, 96, 96);
    run_vectors(0, 7);

    do_reset();
    prog(0, 0, 1);
    prog(1, 4, 2);
    prog(2, 8, 3);
    set_cfg(3, 1, 0, 0, 0, 0);
    run_vectors(8, 14);

    // Watchdog expiry exactly ten RUN cycles after start.
    do_reset();
    prog(0, 100, 25);
    set_cfg(1, 0, 10, 0, 0, 0);
    drive(1, 0, 0, 0);
    check_res("t4_start", mk_res(0, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 1; i <= 9; i++) begin
      drive(0, 0, 0, 0);
      check("t4_wait.done", 32'(bus.done), 32'd0);
    end
    drive(0, 0, 0, 0);
    check_res("t4_timeout", mk_res(1, 0, 2, 0, 0, 0, 0, 0));

    // Rerun from FAIL; final matching store on the last cycle wins.
    drive(1, 0, 0, 0);
    check_res("t4_rerun", mk_res(0, 0, 0, 0, 0, 0, 0, 0));
    check_state("t4_rerun", RUN);
    for (int i = 1; i <= 9; i++) begin
      drive(0, 0, 0, 0);
      check("t4_wait2.done", 32'(bus.done), 32'd0);
    end
    drive(0, 1, 100, 25);
    check_res("t4_lastpass", mk_res(1, 1, 0, 0, 0, 0, 1, 0));

    // Empty table passes after one RUN cycle, ignoring its store.
    set_cfg(0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0);
    check_res("t5_empty_start", mk_res(0, 0, 0, 0, 0, 0, 0, 0));
    check_state("t5_empty_start", RUN);
    drive(0, 1, 104, 99);
    check_res("t5_empty_pass", mk_res(1, 1, 0, 0, 0, 0, 0, 0));

    // Store in the start cycle is not checked; start during RUN is ignored.
    set_cfg(1, 0, 0, 0, 0, 0);
    drive(1, 1, 100, 25);
    check_res("t5_start_store", mk_res(0, 0, 0, 0, 0, 0, 0, 0));
    set_cfg(0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0);
    check_res("t5_restart", mk_res(0, 0, 0, 0, 0, 0, 0, 0));
    check_state("t5_restart", RUN);
    drive(0, 1, 100, 25);
    check_res("t5_pass", mk_res(1, 1, 0, 0, 0, 0, 1, 0));

    // Reset mid-RUN, and table writes outside IDLE are dropped.
    do_reset();
    prog(0, 0, 1);
    prog(1, 4, 2);
    set_cfg(2, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0);
    drive(0, 1, 0, 1);
    check_res("t6_one_match", mk_res(0, 0, 0, 0, 0, 0, 1, 0));
    prog(1, 8, 8);
    check_res("t6_cfg_in_run", mk_res(0, 0, 0, 0, 0, 0, 1, 0));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_res("t6_midreset", mk_res(0, 0, 0, 0, 0, 0, 0, 0));
    check_state("t6_midreset", IDLE);
    drive(1, 0, 0, 0);
    drive(0, 1, 0, 1);
    drive(0, 1, 4, 2);
    check_res("t6_table_kept", mk_res(1, 1, 0, 0, 0, 0, 2, 0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
